// File: rtl/lidar_entropy_encoder.sv
// Adaptive Rice/escape bit packer: symbols become codewords that are shifted one bit
// per cycle into a byte buffer and emitted MSB-first with ready/valid backpressure.
module lidar_entropy_encoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        sym_valid,
  input  logic [15:0] sym_data,
  output logic        sym_ready,
  input  logic        flush,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  input  logic        byte_ready,
  output logic        byte_last,
  output logic        flush_done,
  output logic [3:0]  cur_k,
  output logic [31:0] bits_total
);

  typedef enum logic [2:0] {IDLE, SHIFT, EMIT, PAD, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] cw_q, cw_d;
  logic [5:0]  cw_len_q, cw_len_d;
  logic [7:0]  buf_q, buf_d;
  logic [3:0]  buf_cnt_q, buf_cnt_d;
  logic [19:0] acc_q, acc_d;
  logic [3:0]  cur_k_q, cur_k_d;
  logic [31:0] bits_total_q, bits_total_d;
  logic        flush_pend_q, flush_pend_d;
  logic        byte_valid_q, byte_valid_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic        byte_last_q, byte_last_d;
  logic        flush_done_q, flush_done_d;

  // Position of the leading one, saturated so the parameter fits in 4 bits.
  function automatic logic [3:0] log2_clip(input logic [16:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 1; i < 17; i++)
      if (v[i]) r = (i > 15) ? 4'd15 : 4'(i);
    return r;
  endfunction

  logic [15:0] q_full;
  logic        esc;
  logic [5:0]  q6, k6;
  logic [31:0] unary, lsb, cw_load;
  logic [5:0]  len_load;
  logic [20:0] acc_sum;
  logic [19:0] acc_new;

  always_comb begin
    q_full   = sym_data >> cur_k_q;
    esc      = |q_full[15:4];
    q6       = {2'b00, q_full[3:0]};
    k6       = {2'b00, cur_k_q};
    // Codewords are left-aligned so the next bit to send is always cw_q[31].
    unary    = ~(32'hFFFF_FFFF >> q6);
    lsb      = {16'h0000, sym_data & ((16'd1 << cur_k_q) - 16'd1)};
    cw_load  = esc ? {16'hFFFF, sym_data} : (unary | (lsb << (6'd31 - q6 - k6)));
    len_load = esc ? 6'd32 : (q6 + k6 + 6'd1);
    acc_sum  = {1'b0, acc_q - (acc_q >> 3)} + {5'b00000, sym_data};
    acc_new  = acc_sum[20] ? 20'hFFFFF : acc_sum[19:0];
  end

  always_comb begin
    state_d      = state_q;
    cw_d         = cw_q;
    cw_len_d     = cw_len_q;
    buf_d        = buf_q;
    buf_cnt_d    = buf_cnt_q;
    acc_d        = acc_q;
    cur_k_d      = cur_k_q;
    bits_total_d = bits_total_q;
    flush_pend_d = flush_pend_q;
    byte_valid_d = byte_valid_q;
    byte_data_d  = byte_data_q;
    byte_last_d  = byte_last_q;
    flush_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sym_valid) begin
          cw_d         = cw_load;
          cw_len_d     = len_load;
          acc_d        = acc_new;
          cur_k_d      = log2_clip(acc_new[19:3]);
          flush_pend_d = flush_pend_q | flush;
          state_d      = SHIFT;
        end else if (flush || flush_pend_q) begin
          flush_pend_d = 1'b0;
          if (buf_cnt_q != 4'd0) begin
            state_d = PAD;
          end else begin
            state_d      = DONE;
            flush_done_d = 1'b1;
          end
        end
      end
      SHIFT: begin
        buf_d        = {buf_q[6:0], cw_q[31]};
        buf_cnt_d    = buf_cnt_q + 4'd1;
        cw_d         = cw_q << 1;
        cw_len_d     = cw_len_q - 6'd1;
        bits_total_d = bits_total_q + 32'd1;
        flush_pend_d = flush_pend_q | flush;
        if (buf_cnt_q == 4'd7) begin
          state_d      = EMIT;
          byte_valid_d = 1'b1;
          byte_data_d  = {buf_q[6:0], cw_q[31]};
          byte_last_d  = 1'b0;
        end else if (cw_len_q == 6'd1) begin
          state_d = IDLE;
        end
      end
      PAD: begin
        state_d      = EMIT;
        byte_valid_d = 1'b1;
        byte_data_d  = buf_q << (4'd8 - buf_cnt_q);
        byte_last_d  = 1'b1;
      end
      EMIT: begin
        if (!byte_last_q) flush_pend_d = flush_pend_q | flush;
        if (byte_ready) begin
          byte_valid_d = 1'b0;
          byte_last_d  = 1'b0;
          buf_d        = 8'h00;
          buf_cnt_d    = 4'd0;
          if (byte_last_q) begin
            state_d      = DONE;
            flush_done_d = 1'b1;
          end else if (cw_len_q != 6'd0) begin
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cw_q         <= 32'h0;
      cw_len_q     <= 6'd0;
      buf_q        <= 8'h00;
      buf_cnt_q    <= 4'd0;
      acc_q        <= 20'h0;
      cur_k_q      <= 4'd0;
      bits_total_q <= 32'h0;
      flush_pend_q <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= 8'h00;
      byte_last_q  <= 1'b0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cw_q         <= cw_d;
      cw_len_q     <= cw_len_d;
      buf_q        <= buf_d;
      buf_cnt_q    <= buf_cnt_d;
      acc_q        <= acc_d;
      cur_k_q      <= cur_k_d;
      bits_total_q <= bits_total_d;
      flush_pend_q <= flush_pend_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      byte_last_q  <= byte_last_d;
      flush_done_q <= flush_done_d;
    end
  end

  assign sym_ready  = (state_q == IDLE);
  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign byte_last  = byte_last_q;
  assign flush_done = flush_done_q;
  assign cur_k      = cur_k_q;
  assign bits_total = bits_total_q;

endmodule

// File: tb/tb_lidar_entropy_encoder.sv
// Scoreboard bench for lidar_entropy_encoder: expected bytes are queued when symbols
// are driven and popped by a monitor on each byte handshake.
module tb_lidar_entropy_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sym_valid = 1'b0;
  logic [15:0] sym_data = 16'h0;
  logic        sym_ready;
  logic        flush = 1'b0;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready = 1'b1;
  logic        byte_last;
  logic        flush_done;
  logic [3:0]  cur_k;
  logic [31:0] bits_total;

  lidar_entropy_encoder dut (
    .clk(clk), .reset(reset), .sym_valid(sym_valid), .sym_data(sym_data),
    .sym_ready(sym_ready), .flush(flush), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_ready(byte_ready), .byte_last(byte_last),
    .flush_done(flush_done), .cur_k(cur_k), .bits_total(bits_total)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: bit queue, accumulator, parameter and bit count.
  logic [8:0]  exp_q[$];
  bit          mbits[$];
  int unsigned m_acc = 0;
  int          m_k = 0;
  logic [31:0] m_total = 32'h0;
  bit          model_on = 1'b1;
  bit          bp_done = 1'b0;

  function automatic void m_reset();
    exp_q.delete();
    mbits.delete();
    m_acc   = 0;
    m_k     = 0;
    m_total = 32'h0;
  endfunction

  function automatic void m_bit(bit b);
    logic [7:0] by;
    mbits.push_back(b);
    m_total = m_total + 32'd1;
    if (mbits.size() == 8) begin
      for (int i = 0; i < 8; i++) by[7-i] = mbits[i];
      if (model_on) exp_q.push_back({1'b0, by});
      mbits.delete();
    end
  endfunction

  function automatic void m_sym(int unsigned v);
    int unsigned q, a, t;
    q = v >> m_k;
    if (q >= 16) begin
      for (int i = 0; i < 16; i++) m_bit(1'b1);
      for (int i = 15; i >= 0; i--) m_bit(bit'(v >> i));
    end else begin
      for (int i = 0; i < int'(q); i++) m_bit(1'b1);
      m_bit(1'b0);
      for (int i = m_k - 1; i >= 0; i--) m_bit(bit'(v >> i));
    end
    a = m_acc - (m_acc >> 3) + v;
    if (a > 32'hFFFFF) a = 32'hFFFFF;
    m_acc = a;
    t = a >> 3;
    m_k = 0;
    while (t > 1) begin
      t = t >> 1;
      m_k++;
    end
    if (m_k > 15) m_k = 15;
  endfunction

  function automatic void m_flush();
    logic [7:0] by;
    if (mbits.size() > 0) begin
      by = 8'h00;
      for (int i = 0; i < mbits.size(); i++) by[7-i] = mbits[i];
      if (model_on) exp_q.push_back({1'b1, by});
      mbits.delete();
    end
  endfunction

  // Byte monitor: the handshake seen here is the one the DUT takes at the next rising edge.
  always @(negedge clk) begin : mon
    logic [8:0] e;
    if (!reset && byte_valid && byte_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL byte_unexpected: got data=%02h last=%0b, required no byte", byte_data, byte_last);
      end else begin
        e = exp_q.pop_front();
        if ({byte_last, byte_data} !== e) begin
          fails++;
          $display("FAIL byte: got data=%02h last=%0b, required data=%02h last=%0b",
                   byte_data, byte_last, e[7:0], e[8]);
        end else begin
          $display("[TB] byte %02h last=%0b", byte_data, byte_last);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    m_reset();
  endtask

  task automatic send_sym(input logic [15:0] v);
    int n = 0;
    while (!sym_ready && n < 400) begin
      step();
      n++;
    end
    if (!sym_ready) begin
      tests++;
      fails++;
      $display("FAIL sym_ready_timeout: got sym_ready=%0b, required 1", sym_ready);
    end else begin
      sym_data  = v;
      sym_valid = 1'b1;
      m_sym(int'(v));
      step();
      sym_valid = 1'b0;
      $display("[TB] sym %0d accepted, cur_k now %0d", v, cur_k);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!sym_ready && n < 400) begin
      step();
      n++;
    end
    tests++;
    if (!sym_ready || exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: got sym_ready=%0b pending=%0d, required 1 and 0", name, sym_ready, exp_q.size());
    end
  endtask

  task automatic do_flush(input string name);
    int  n = 0;
    bit  found = 1'b0;
    while (!sym_ready && n < 400) begin
      step();
      n++;
    end
    flush = 1'b1;
    m_flush();
    step();
    flush = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (flush_done) begin
        found = 1'b1;
        break;
      end
      step();
    end
    tests++;
    if (!found || exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_flush_done: got done=%0b pending=%0d, required 1 and 0", name, found, exp_q.size());
    end else begin
      $display("[TB] %s flush done", name);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if ({sym_ready, byte_valid, byte_data, byte_last, flush_done, cur_k, bits_total} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 32'd0}) begin
      fails++;
      $display("FAIL reset_values: got rdy=%0b vld=%0b data=%02h last=%0b done=%0b k=%0d total=%0d, required 1 0 00 0 0 0 0",
               sym_ready, byte_valid, byte_data, byte_last, flush_done, cur_k, bits_total);
    end
  endtask

  task automatic test_short_flush();
    apply_reset();
    model_on = 1'b0;
    exp_q.push_back({1'b1, 8'hE0});
    send_sym(16'd3);
    do_flush("short");
    tests++;
    if (bits_total !== 32'd4 || cur_k !== 4'd0) begin
      fails++;
      $display("FAIL short_counts: got total=%0d k=%0d, required 4 0", bits_total, cur_k);
    end
  endtask

  task automatic test_zeros();
    apply_reset();
    model_on = 1'b0;
    exp_q.push_back({1'b0, 8'h00});
    for (int i = 0; i < 8; i++) send_sym(16'd0);
    wait_idle("zeros");
    tests++;
    if (bits_total !== 32'd8) begin
      fails++;
      $display("FAIL zeros_total: got %0d, required 8", bits_total);
    end
  endtask

  task automatic test_empty_flush();
    do_flush("empty");
    tests++;
    if (bits_total !== 32'd8) begin
      fails++;
      $display("FAIL empty_total: got %0d, required 8", bits_total);
    end
  endtask

  task automatic test_escape();
    apply_reset();
    model_on = 1'b0;
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b0, 8'h00});
    exp_q.push_back({1'b0, 8'h10});
    send_sym(16'd16);
    wait_idle("escape");
    tests++;
    if (bits_total !== 32'd32 || cur_k !== 4'd1) begin
      fails++;
      $display("FAIL escape_counts: got total=%0d k=%0d, required 32 1", bits_total, cur_k);
    end
  endtask

  task automatic test_adapt();
    apply_reset();
    model_on = 1'b0;
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b0, 8'h03});
    exp_q.push_back({1'b0, 8'hE8});
    exp_q.push_back({1'b0, 8'hFF});
    exp_q.push_back({1'b0, 8'hFE});
    exp_q.push_back({1'b1, 8'hA0});
    send_sym(16'd1000);
    tests++;
    if (cur_k !== 4'd6) begin
      fails++;
      $display("FAIL adapt_k: got %0d, required 6", cur_k);
    end
    send_sym(16'd1000);
    do_flush("adapt");
    tests++;
    if (bits_total !== 32'd54) begin
      fails++;
      $display("FAIL adapt_total: got %0d, required 54", bits_total);
    end
  endtask

  function automatic logic [15:0] rand_sym();
    case ($urandom_range(0, 3))
      0:       return 16'($urandom_range(0, 7));
      1:       return 16'($urandom_range(0, 255));
      2:       return 16'($urandom_range(0, 4095));
      default: return 16'($urandom_range(0, 65535));
    endcase
  endfunction

  task automatic test_back_to_back();
    apply_reset();
    model_on = 1'b1;
    for (int i = 0; i < 24; i++) send_sym(rand_sym());
    do_flush("b2b");
    tests++;
    if (bits_total !== m_total || cur_k !== 4'(m_k)) begin
      fails++;
      $display("FAIL b2b_counts: got total=%0d k=%0d, required %0d %0d", bits_total, cur_k, m_total, m_k);
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] d;
    bit         stable;
    apply_reset();
    model_on   = 1'b1;
    bp_done    = 1'b0;
    byte_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send_sym(rand_sym());
        do_flush("bp");
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          if (byte_valid && !byte_ready) begin
            d = {byte_last, byte_data};
            stable = 1'b1;
            for (int i = 0; i < 5; i++) begin
              step();
              if ({byte_last, byte_data} !== d || !byte_valid || sym_ready) stable = 1'b0;
            end
            tests++;
            if (!stable) begin
              fails++;
              $display("FAIL bp_stable: got data=%02h vld=%0b rdy=%0b, required data=%02h vld=1 rdy=0",
                       byte_data, byte_valid, sym_ready, d[7:0]);
            end
            byte_ready = 1'b1;
            step();
            byte_ready = 1'b0;
          end else begin
            step();
          end
        end
      end
    join
    byte_ready = 1'b1;
    tests++;
    if (bits_total !== m_total) begin
      fails++;
      $display("FAIL bp_total: got %0d, required %0d", bits_total, m_total);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    model_on = 1'b0;
    send_sym(16'd16);
    repeat (5) step();
    #3;
    reset = 1'b1;
    #1;
    tests++;
    if ({sym_ready, byte_valid, byte_data, byte_last, flush_done, cur_k, bits_total} !== {1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 32'd0}) begin
      fails++;
      $display("FAIL async_reset: got rdy=%0b vld=%0b data=%02h last=%0b done=%0b k=%0d total=%0d, required 1 0 00 0 0 0 0",
               sym_ready, byte_valid, byte_data, byte_last, flush_done, cur_k, bits_total);
    end
    m_reset();
    step();
    reset = 1'b0;
    exp_q.push_back({1'b1, 8'hE0});
    send_sym(16'd3);
    do_flush("after_reset");
    tests++;
    if (bits_total !== 32'd4) begin
      fails++;
      $display("FAIL after_reset_total: got %0d, required 4", bits_total);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_short_flush();
    test_zeros();
    test_empty_flush();
    test_escape();
    test_adapt();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
